bidir_serial_receiver: RTL and testbench
========================================

# bidir_serial_receiver

Deserializing receiver for the serial stream produced by the bidirectional shift register. It captures a `WIDTH`-bit word one bit per qualified clock, in either shift direction, and presents the word on a parallel valid/ready output register. It sits at the far end of a shift link and hands completed words to downstream logic. The block flags words lost because the output register was still occupied.

## Interface
- `WIDTH`, default 4: word length in bits; must be ≥ 2.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a word; sampled only in IDLE.
- `mode`, input, 1: direction, latched at start. 0 = shift-right link, LSB first. 1 = shift-left link, MSB first.
- `sin`, input, 1: serial data bit.
- `sin_valid`, input, 1: `sin` qualifier; a bit is captured only on edges where this is 1 in SHIFT.
- `dout`, output, WIDTH: received word (registered).
- `dout_n`, output, WIDTH: bitwise complement of `dout` (registered).
- `dout_valid`, output, 1: `dout` holds an unconsumed word.
- `dout_ready`, input, 1: consumer accepts `dout` on an edge where `dout_valid` & `dout_ready`.
- `busy`, output, 1: high while in SHIFT.
- `overrun`, output, 1: sticky; a completed word was dropped.

## Operation
- State machine has two states.
  - IDLE: `start`=1 latches `mode` into `dir`, clears the bit counter and shift register, and moves to SHIFT.
  - SHIFT: each edge with `sin_valid`=1 captures `sin`.
    - `dir`=0: `sr <= {sin, sr[WIDTH-1:1]}`.
    - `dir`=1: `sr <= {sr[WIDTH-2:0], sin}`.
    - The counter increments, width clog2(WIDTH), with no wrap inside a word.
- Word completion is the capture where the counter equals WIDTH-1. That edge returns the FSM to IDLE. The next shift-register value, including the current bit, is "the word".
  - If the output register is free (`dout_valid`=0, or `dout_valid`&`dout_ready` on the same edge), load `dout`=word, `dout_n`=~word, `dout_valid`=1.
  - Otherwise drop the word, set `overrun`=1, and leave `dout`/`dout_valid` unchanged.
- The output handshake is independent of the FSM. `dout_valid` clears on an accepting edge unless a new word loads on that same edge, in which case it stays 1 with the new data.
- `mode` changes and `start` pulses during SHIFT are ignored.
- `sin_valid`=0 stalls capture indefinitely, with no timeout.
- `overrun` clears only on reset.

## Timing
- Reset (async assert, immediate):
  - FSM returns to IDLE.
  - `sr`, counter, and `dir` clear to 0.
  - `dout`=0, `dout_n`=all ones, `dout_valid`=0, `busy`=0, `overrun`=0.
- Reset mid-word discards the partial word. No `dout_valid` follows.
- `busy` rises on the edge after `start` is sampled in IDLE, and falls on the completion edge.
- Latency: `dout_valid` rises on the same edge that captures the last bit, visible in the following cycle. A full word needs a minimum of 1 start edge plus WIDTH capture edges.
- Back-to-back words: `start` may be high in the cycle right after completion, since the FSM is already in IDLE.
- `dout`/`dout_n` are stable while `dout_valid`=1 and not accepted.

## Test plan
- Reset, then `start`, `mode`=0, bits 1,0,1,1 with `sin_valid`=1 → `dout`=1101, `dout_n`=0010, `dout_valid`=1 after 4 capture edges, `busy` high for exactly 4 cycles.
- `mode`=1, bits 1,0,1,1 → `dout`=1011. Toggling `mode` mid-word does not change the result.
- `mode`=0, bits 0,1,1,0 with `sin_valid` low for 3 cycles between bits 2 and 3 → `dout`=0110, with completion delayed by exactly 3 cycles.
- Hold `dout_ready`=0 and receive word A=1001, then word B=0111 → `dout` stays 1001, `overrun`=1 at B's completion. Pulse `dout_ready` → `dout_valid`=0, `overrun` stays 1.
- `dout_valid`=1 with `dout_ready`=1 on the same edge word B completes → `dout`=B, `dout_valid` stays 1, `overrun`=0.
- Assert `rst` asynchronously after 2 bits → all outputs return to reset values immediately. A subsequent full word receives correctly.

Source files
------------

// File: rtl/bidir_serial_receiver.sv
// Deserializing receiver for a bidirectional shift link.
// Collects WIDTH bits, one per qualified clock, in the direction latched at
// start. The finished word goes into a valid/ready output register. A word
// that finishes while that register is still occupied is dropped, and the
// sticky overrun flag records the loss.
module bidir_serial_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_n,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic             dir_q;
  logic [CW-1:0]    bitCnt_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic             busy_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] doutN_q;
  logic             doutValid_q;
  logic             overrun_q;

  logic             capture;
  logic             wordDone;
  logic             outFree;

  assign capture  = (state_q == SHIFT) && sin_valid;
  assign wordDone = capture && (bitCnt_q == LAST_BIT);
  assign outFree  = !doutValid_q || dout_ready;

  // Next shift-register value with the incoming bit inserted at the end that matches the link direction
  always_comb begin
    sr_d = sr_q;
    if (dir_q) begin
      sr_d = {sr_q[WIDTH-2:0], sin};
    end else begin
      sr_d = {sin, sr_q[WIDTH-1:1]};
    end
  end

  // Two-state capture FSM; busy is a registered copy of "in SHIFT"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      bitCnt_q <= '0;
      sr_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dir_q    <= mode;
            bitCnt_q <= '0;
            sr_q     <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (sin_valid) begin
            sr_q <= sr_d;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_q <= '0;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else begin
              bitCnt_q <= bitCnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load a finished word when free, otherwise flag the loss; consumer handshake clears valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q      <= '0;
      doutN_q     <= '1;
      doutValid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wordDone && outFree) begin
        dout_q      <= sr_d;
        doutN_q     <= ~sr_d;
        doutValid_q <= 1'b1;
      end else begin
        if (wordDone) begin
          overrun_q <= 1'b1;
        end
        if (doutValid_q && dout_ready) begin
          doutValid_q <= 1'b0;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_n     = doutN_q;
  assign dout_valid = doutValid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_bidir_serial_receiver.sv
// Directed self-checking bench for bidir_serial_receiver (WIDTH = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// half a cycle after the rising edge that produced them.
module tb_bidir_serial_receiver;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             mode;
  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_n;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;

  int compareCount;
  int mismatchCount;
  int busyCnt;

  bidir_serial_receiver #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dout       (dout),
    .dout_n     (dout_n),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one set of inputs and advance through one rising edge
  task automatic applyStimulus(input logic st, input logic md, input logic b,
                               input logic bv, input logic rdy);
    start      = st;
    mode       = md;
    sin        = b;
    sin_valid  = bv;
    dout_ready = rdy;
    @(negedge clk);
  endtask

  // Start a word and send seq[0] first. Start pulses and a flipped mode in the middle must be ignored.
  // readyLast drives dout_ready on the completion edge. Busy is counted before each capture edge.
  task automatic sendWord(input logic md, input logic [3:0] seq, input logic readyLast,
                          output int busyCount);
    busyCount = 0;
    applyStimulus(1'b1, md, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      if (busy) busyCount++;
      applyStimulus((i == 1 || i == 2), ~md, seq[i], 1'b1, (i == WIDTH-1) ? readyLast : 1'b0);
    end
    start = 1'b0;
    mode  = md;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst        = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    dout_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values
    checkOutput("rst_dout", dout, 4'h0);
    checkOutput("rst_dout_n", dout_n, 4'hF);
    checkOutput("rst_valid", dout_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_overrun", overrun, 1'b0);

    // LSB-first word: arrival 1,0,1,1 -> 1101
    sendWord(1'b0, 4'b1101, 1'b0, busyCnt);
    checkOutput("w1_dout", dout, 4'b1101);
    checkOutput("w1_dout_n", dout_n, 4'b0010);
    checkOutput("w1_valid", dout_valid, 1'b1);
    checkOutput("w1_busy_cycles", busyCnt, 4);
    checkOutput("w1_busy_after", busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("w1_accept_valid", dout_valid, 1'b0);

    // MSB-first word with mode toggled mid-word: arrival 1,0,1,1 -> 1011
    sendWord(1'b1, 4'b1101, 1'b0, busyCnt);
    checkOutput("w2_dout", dout, 4'b1011);
    checkOutput("w2_dout_n", dout_n, 4'b0100);
    checkOutput("w2_valid", dout_valid, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("w2_accept_valid", dout_valid, 1'b0);

    // LSB-first 0,1,1,0 with a 3-cycle stall between bits 2 and 3 -> 0110
    busyCnt = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (busy) busyCnt++;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (busy) busyCnt++;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (busy) busyCnt++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (busy) busyCnt++;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("w3_valid_early", dout_valid, 1'b0);
    if (busy) busyCnt++;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("w3_dout", dout, 4'b0110);
    checkOutput("w3_valid", dout_valid, 1'b1);
    checkOutput("w3_busy_cycles", busyCnt, 7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("w3_accept_valid", dout_valid, 1'b0);

    // Overrun: A = 1001 held unconsumed, then B = 0111 is dropped
    sendWord(1'b0, 4'b1001, 1'b0, busyCnt);
    checkOutput("ovr_a_dout", dout, 4'b1001);
    checkOutput("ovr_pre_flag", overrun, 1'b0);
    sendWord(1'b0, 4'b0111, 1'b0, busyCnt);
    checkOutput("ovr_dout_held", dout, 4'b1001);
    checkOutput("ovr_dout_n_held", dout_n, 4'b0110);
    checkOutput("ovr_valid_held", dout_valid, 1'b1);
    checkOutput("ovr_flag", overrun, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_accept_valid", dout_valid, 1'b0);
    checkOutput("ovr_sticky", overrun, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clear overrun, then accept A on the same edge B completes
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("ovr_cleared_by_rst", overrun, 1'b0);
    sendWord(1'b0, 4'b1001, 1'b0, busyCnt);
    checkOutput("same_edge_a_dout", dout, 4'b1001);
    sendWord(1'b0, 4'b0111, 1'b1, busyCnt);
    checkOutput("same_edge_dout", dout, 4'b0111);
    checkOutput("same_edge_valid", dout_valid, 1'b1);
    checkOutput("same_edge_overrun", overrun, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stable_dout", dout, 4'b0111);
    checkOutput("stable_valid", dout_valid, 1'b1);

    // Async reset after 2 bits while an unconsumed word is held
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_rst_busy", busy, 1'b1);
    sin_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_busy", busy, 1'b0);
    checkOutput("async_dout", dout, 4'h0);
    checkOutput("async_dout_n", dout_n, 4'hF);
    checkOutput("async_valid", dout_valid, 1'b0);
    checkOutput("async_overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("post_rst_no_valid", dout_valid, 1'b0);

    // Full MSB-first word after reset: arrival 0,1,1,0 -> 0110
    sendWord(1'b1, 4'b0110, 1'b0, busyCnt);
    checkOutput("post_rst_dout", dout, 4'b0110);
    checkOutput("post_rst_dout_n", dout_n, 4'b1001);
    checkOutput("post_rst_valid", dout_valid, 1'b1);
    checkOutput("post_rst_busy_cycles", busyCnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
